// File: rtl/pass_request_pkg.sv
// rtl/pass_request_pkg.sv - shared state enum, default parameters and counter sizing for pass_request
package pass_request_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLDOFF_CYCLES  = 2048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_FIRE,
        ST_HOLDOFF,
        ST_WAIT_RELEASE
    } state_t;

    // Counter width that can hold the larger of the two terminal counts without wrapping
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for an asynchronous single-bit input
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw input through the chain; only the last stage is used downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pass_request.sv
// rtl/pass_request.sv - debounced pedestrian button to one-cycle pass pulse with holdoff
module pass_request
    import pass_request_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       enable,
    output logic       pass,
    output logic       busy,
    output logic [7:0] req_cnt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLDOFF_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          btn_s;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    req_cnt_nx;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    // Next-state, counter and pass-counter decisions for the press sequence
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        req_cnt_nx = req_cnt;
        case (state)
            ST_IDLE: begin
                if (btn_s && enable) begin
                    state_nx = ST_DEBOUNCE;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_s || !enable) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nx = ST_FIRE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            ST_FIRE: begin
                state_nx = ST_HOLDOFF;
                cnt_nx   = CNT_ONE;
                if (req_cnt != 8'hFF) begin
                    req_cnt_nx = req_cnt + 8'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == HOLD_LAST) begin
                    state_nx = ST_WAIT_RELEASE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            ST_WAIT_RELEASE: begin
                cnt_nx = '0;
                if (!btn_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register; pass and busy are registered decodes of the next state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req_cnt <= 8'd0;
            pass    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            req_cnt <= req_cnt_nx;
            pass    <= (state_nx == ST_FIRE);
            busy    <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pass_request.sv
// tb/tb_pass_request.sv - scoreboard bench for pass_request against a run-length press model
module tb_pass_request;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int HOLD = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       enable = 1'b0;
    logic       pass;
    logic       busy;
    logic [7:0] req_cnt;

    int compared   = 0;
    int mismatched = 0;

    // reference model state: edge count since reset, run length of accepted high samples,
    // end of the lockout window, and whether a release is still owed
    int cyc      = 0;
    int run      = 0;
    int lock_end = -1;
    int inc_edge = -1;
    bit waiting  = 1'b0;
    int m_count  = 0;
    bit m_busy   = 1'b0;
    bit m_s      = 1'b0;
    bit hist[$];
    int exp_q[$];
    int exp_rd   = 0;
    int dut_passes = 0;
    bit done     = 1'b0;

    pass_request #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .enable  (enable),
        .pass    (pass),
        .busy    (busy),
        .req_cnt (req_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a press is accepted after DEB+1 consecutive edges of synchronized
    // button and enable high; it then locks out for one fire edge plus HOLD edges and
    // needs a released button before another run can begin.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run      = 0;
            lock_end = -1;
            inc_edge = -1;
            waiting  = 1'b0;
            m_count  = 0;
            m_busy   = 1'b0;
            hist.delete();
        end else begin
            cyc++;
            m_s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
            hist.push_back(btn);
            if (hist.size() > SYNC) void'(hist.pop_front());
            if (cyc == inc_edge && m_count < 255) m_count++;
            if (cyc <= lock_end) begin
                run = 0;
            end else if (waiting) begin
                if (!m_s) waiting = 1'b0;
            end else if (m_s && enable) begin
                run++;
                if (run == DEB + 1) begin
                    exp_q.push_back(cyc);
                    run      = 0;
                    lock_end = cyc + HOLD + 1;
                    inc_edge = cyc + 1;
                    waiting  = 1'b1;
                end
            end else begin
                run = 0;
            end
            m_busy = (run > 0) || (cyc <= lock_end) || waiting;
        end
    end

    // Monitor: compares every cycle on the falling edge and pops expected passes
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            compared++;
            if (busy !== m_busy) begin
                mismatched++;
                $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy);
            end
            compared++;
            if (req_cnt !== 8'(m_count)) begin
                mismatched++;
                $display("FAIL req_cnt cyc=%0d got=%0d exp=%0d", cyc, req_cnt, m_count);
            end
            if (pass === 1'b1) begin
                dut_passes++;
                compared++;
                if (exp_rd >= exp_q.size() || exp_q[exp_rd] != cyc) begin
                    mismatched++;
                    $display("FAIL pass_timing cyc=%0d got=pass exp_edge=%0d", cyc,
                             (exp_rd < exp_q.size()) ? exp_q[exp_rd] : -1);
                end
                if (exp_rd < exp_q.size() && exp_q[exp_rd] <= cyc) exp_rd++;
            end else if (pass !== 1'b0) begin
                compared++;
                mismatched++;
                $display("FAIL pass_x cyc=%0d got=%b exp=0/1", cyc, pass);
            end else if (exp_rd < exp_q.size() && exp_q[exp_rd] <= cyc) begin
                compared++;
                mismatched++;
                $display("FAIL pass_missing cyc=%0d got=0 exp_edge=%0d", cyc, exp_q[exp_rd]);
                exp_rd++;
            end
        end
        compared++;
        if (exp_rd != exp_q.size()) begin
            mismatched++;
            $display("FAIL pending_passes got=%0d exp=%0d", exp_rd, exp_q.size());
        end
        compared++;
        if (dut_passes != exp_q.size()) begin
            mismatched++;
            $display("FAIL pass_total got=%0d exp=%0d", dut_passes, exp_q.size());
        end
        compared++;
        if (req_cnt !== 8'd255) begin
            mismatched++;
            $display("FAIL req_cnt_saturated got=%0d exp=255", req_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic press(input int len, input bit en, input int gap);
        btn    = 1'b1;
        enable = en;
        step(len);
        btn = 1'b0;
        step(gap);
    endtask

    // Stimulus: inputs change 2 ns after each falling edge
    initial begin
        int len;
        bit en;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
        press(40, 1'b1, HOLD + 40);
        press(10, 1'b1, 50);
        press(30, 1'b1, 40);
        press(30, 1'b1, HOLD + 40);
        press(300, 1'b1, HOLD + 40);
        press(30, 1'b0, 20);
        btn    = 1'b1;
        enable = 1'b1;
        step(12);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(40);
        btn = 1'b0;
        step(HOLD + 40);
        for (int i = 0; i < 300; i++) begin
            if (i < 40) begin
                en  = ($urandom_range(3, 0) != 0);
                len = $urandom_range(40, 3);
            end else begin
                en  = 1'b1;
                len = $urandom_range(40, 20);
            end
            press(len, en, HOLD + 20 + $urandom_range(15, 0));
        end
        done = 1'b1;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
